// File: rtl/wd_seq_pkg.sv
// Shared types, bus codes and constants for the watchdog service sequencer.
package wd_seq_pkg;

  typedef enum logic [2:0] {StIdle, StUnlk1, StUnlk2, StSlot, StRun} state_e;
  typedef enum logic [1:0] {OpCfg, OpInit, OpKick} op_e;

  localparam logic [7:0] UNLK_A   = 8'hAA;
  localparam logic [7:0] UNLK_B   = 8'h55;
  localparam logic [7:0] CMD_INIT = 8'h08;
  localparam logic [7:0] CMD_KICK = 8'h04;

  // Kick SLOT1 must trail the previous SLOT4 by the two unlock cycles.
  localparam logic [8:0] MIN_TGT  = 9'd6;

  localparam logic [1:0] ABUS_FRAME = 2'b00;
  localparam logic [1:0] ABUS_SERV  = 2'b01;
  localparam logic [1:0] ABUS_CTRL  = 2'b10;
  localparam logic [1:0] ABUS_RLIM  = 2'b11;

  localparam logic [1:0] IDLE_ABUS = ABUS_CTRL;
  localparam logic [7:0] IDLE_DBUS = 8'h00;

  // Midpoint of the open window: S + ((F - S) >> 1), 9-bit intermediate.
  function automatic logic [8:0] calc_tgt(input logic [7:0] f, input logic [7:0] s);
    logic [8:0] w_diff;
    w_diff = {1'b0, f} - {1'b0, s};
    return {1'b0, s} + {1'b0, w_diff[8:1]};
  endfunction

endpackage

// File: rtl/wd_service_sequencer_if.sv
// Watchdog register bus: sequencer drives ABUS/DBUS, watchdog returns RSTOUT.
interface wd_service_sequencer_if;
  logic [1:0] ABUS;
  logic [7:0] DBUS;
  logic       WD_RSTOUT;

  modport master (output ABUS, output DBUS, input WD_RSTOUT);
  modport slave  (input ABUS, input DBUS, output WD_RSTOUT);
endinterface

// File: rtl/wd_window_timer.sv
// Service-window timer: saturating t counter and kick-scheduling compare.
module wd_window_timer
  import wd_seq_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_late,
  input  logic [7:0] i_frame,
  input  logic [7:0] i_serv,
  output logic       o_fire
);

  logic [7:0] r_t;
  logic [8:0] w_target;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_t <= 8'd0;
    end else if (r_t != 8'hFF) begin
      r_t <= r_t + 8'd1;
    end
  end

  assign w_target = i_late ? {1'b0, i_frame} : calc_tgt(i_frame, i_serv);

  // Fire three cycles ahead so UNLK1 shows at target-2 and SLOT1 at target.
  assign o_fire = (({1'b0, r_t} + 9'd3) == w_target);

endmodule

// File: rtl/wd_service_sequencer.sv
// Watchdog service sequencer: unlock/config/init, then periodic kicks in RUN.
// Optional WDSEQ_FAULT_INJ_EN adds INJ_LATE to push one kick out to t == F.
module wd_service_sequencer
  import wd_seq_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  STOP,
  input  logic [7:0]            CFG_FRAME,
  input  logic [7:0]            CFG_SERV,
  input  logic [7:0]            CFG_RLIM,
`ifdef WDSEQ_FAULT_INJ_EN
  input  logic                  INJ_LATE,
`endif
  wd_service_sequencer_if.master wd,
  output logic                  BUSY,
  output logic                  RUNNING,
  output logic                  ERR_CFG,
  output logic                  FAULT,
  output logic [15:0]           KICK_CNT
);

  state_e      r_state;
  op_e         r_op;
  logic [1:0]  r_slot;
  logic [7:0]  r_frame, r_serv, r_rlim;
  logic [1:0]  r_abus;
  logic [7:0]  r_dbus;
  logic        r_busy, r_running, r_err, r_fault;
  logic [15:0] r_kick_cnt;

  logic w_cfg_ok, w_fire, w_clr, w_late;

  assign w_cfg_ok = ({1'b0, CFG_FRAME} >= ({1'b0, CFG_SERV} + 9'd2)) &&
                    (calc_tgt(CFG_FRAME, CFG_SERV) >= MIN_TGT);

  // t restarts in the cycle INIT/KICK SLOT1 is on the bus.
  assign w_clr = (r_state == StUnlk2) && (r_op != OpCfg);

  function automatic logic [9:0] slot_bus(input op_e op, input logic [1:0] slot,
                                          input logic [7:0] f, input logic [7:0] s,
                                          input logic [7:0] r);
    logic [9:0] w_bus;
    w_bus = {IDLE_ABUS, IDLE_DBUS};
    case (op)
      OpCfg: begin
        case (slot)
          2'd0:    w_bus = {ABUS_FRAME, f};
          2'd1:    w_bus = {ABUS_SERV, s};
          2'd2:    w_bus = {ABUS_RLIM, r};
          default: w_bus = {ABUS_CTRL, 8'h00};
        endcase
      end
      OpInit:  if (slot == 2'd0) w_bus = {ABUS_CTRL, CMD_INIT};
      OpKick:  if (slot == 2'd0) w_bus = {ABUS_CTRL, CMD_KICK};
      default: w_bus = {IDLE_ABUS, IDLE_DBUS};
    endcase
    return w_bus;
  endfunction

`ifdef WDSEQ_FAULT_INJ_EN
  logic r_armed;
  always_ff @(posedge CLK) begin
    if (RST || r_state == StIdle) begin
      r_armed <= 1'b0;
    end else if (r_state == StUnlk2 && r_op == OpKick) begin
      r_armed <= 1'b0;
    end else if (r_running && INJ_LATE) begin
      r_armed <= 1'b1;
    end
  end
  assign w_late = r_armed;
`else
  assign w_late = 1'b0;
`endif

  wd_window_timer u_timer (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_clr   (w_clr),
    .i_late  (w_late),
    .i_frame (r_frame),
    .i_serv  (r_serv),
    .o_fire  (w_fire)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= StIdle;
      r_op       <= OpCfg;
      r_slot     <= 2'd0;
      r_frame    <= 8'h00;
      r_serv     <= 8'h00;
      r_rlim     <= 8'h00;
      r_abus     <= IDLE_ABUS;
      r_dbus     <= IDLE_DBUS;
      r_busy     <= 1'b0;
      r_running  <= 1'b0;
      r_err      <= 1'b0;
      r_fault    <= 1'b0;
      r_kick_cnt <= 16'h0000;
    end else if (r_busy && wd.WD_RSTOUT) begin
      r_state   <= StIdle;
      r_abus    <= IDLE_ABUS;
      r_dbus    <= IDLE_DBUS;
      r_busy    <= 1'b0;
      r_running <= 1'b0;
      r_fault   <= 1'b1;
    end else begin
      case (r_state)
        StIdle: begin
          if (START) begin
            if (w_cfg_ok) begin
              r_frame <= CFG_FRAME;
              r_serv  <= CFG_SERV;
              r_rlim  <= CFG_RLIM;
              r_err   <= 1'b0;
              r_fault <= 1'b0;
              r_op    <= OpCfg;
              r_state <= StUnlk1;
              r_abus  <= ABUS_FRAME;
              r_dbus  <= UNLK_A;
              r_busy  <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        StUnlk1: begin
          r_state <= StUnlk2;
          r_abus  <= ABUS_FRAME;
          r_dbus  <= UNLK_B;
        end
        StUnlk2: begin
          r_state          <= StSlot;
          r_slot           <= 2'd0;
          {r_abus, r_dbus} <= slot_bus(r_op, 2'd0, r_frame, r_serv, r_rlim);
          if (r_op == OpKick) r_kick_cnt <= r_kick_cnt + 16'd1;
        end
        StSlot: begin
          if (r_slot != 2'd3) begin
            r_slot           <= r_slot + 2'd1;
            {r_abus, r_dbus} <= slot_bus(r_op, r_slot + 2'd1, r_frame, r_serv, r_rlim);
          end else if (STOP) begin
            r_state   <= StIdle;
            r_abus    <= IDLE_ABUS;
            r_dbus    <= IDLE_DBUS;
            r_busy    <= 1'b0;
            r_running <= 1'b0;
          end else if (r_op == OpCfg) begin
            r_op    <= OpInit;
            r_state <= StUnlk1;
            r_abus  <= ABUS_FRAME;
            r_dbus  <= UNLK_A;
          end else begin
            r_running <= 1'b1;
            if (w_fire) begin
              r_op    <= OpKick;
              r_state <= StUnlk1;
              r_abus  <= ABUS_FRAME;
              r_dbus  <= UNLK_A;
            end else begin
              r_state <= StRun;
              r_abus  <= IDLE_ABUS;
              r_dbus  <= IDLE_DBUS;
            end
          end
        end
        StRun: begin
          if (STOP) begin
            r_state   <= StIdle;
            r_busy    <= 1'b0;
            r_running <= 1'b0;
          end else if (w_fire) begin
            r_op    <= OpKick;
            r_state <= StUnlk1;
            r_abus  <= ABUS_FRAME;
            r_dbus  <= UNLK_A;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign wd.ABUS  = r_abus;
  assign wd.DBUS  = r_dbus;
  assign BUSY     = r_busy;
  assign RUNNING  = r_running;
  assign ERR_CFG  = r_err;
  assign FAULT    = r_fault;
  assign KICK_CNT = r_kick_cnt;

endmodule

// File: tb/tb_wd_service_sequencer.sv
// Bench for wd_service_sequencer: directed scenarios then random traffic vs a beat-queue model.
module tb_wd_service_sequencer;

  logic        CLK = 1'b0;
  logic        RST, START, STOP, inj;
  logic [7:0]  cfg_f, cfg_s, cfg_r;
  logic        busy, running, err_cfg, fault;
  logic [15:0] kick_cnt;

  int n_cmp = 0;
  int n_err = 0;

  wd_service_sequencer_if bus_if ();

  always #5 CLK = ~CLK;

  wd_service_sequencer dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .STOP      (STOP),
    .CFG_FRAME (cfg_f),
    .CFG_SERV  (cfg_s),
    .CFG_RLIM  (cfg_r),
`ifdef WDSEQ_FAULT_INJ_EN
    .INJ_LATE  (inj),
`endif
    .wd        (bus_if),
    .BUSY      (busy),
    .RUNNING   (running),
    .ERR_CFG   (err_cfg),
    .FAULT     (fault),
    .KICK_CNT  (kick_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: each sequence is a queue of pending {ABUS,DBUS} beats.
  logic [9:0]  q[$];
  logic [9:0]  m_bus;
  logic [7:0]  m_f, m_s, m_r;
  logic [15:0] m_kcnt;
  int          m_seq, m_pos, m_t, m_tgt;
  bit          m_busy, m_run, m_err, m_fault, m_armed, m_hit_slot1;

  task automatic push_seq(input int kind);
    q.push_back(10'h0AA);
    q.push_back(10'h055);
    if (kind == 0) begin
      q.push_back({2'b00, m_f});
      q.push_back({2'b01, m_s});
      q.push_back({2'b11, m_r});
    end else begin
      q.push_back(kind == 1 ? 10'h208 : 10'h204);
      q.push_back(10'h200);
      q.push_back(10'h200);
    end
    q.push_back(10'h200);
    m_seq = kind;
    m_pos = -1;
  endtask

  task automatic advance();
    m_bus = q.pop_front();
    m_pos++;
    if (m_pos == 2 && m_seq != 0) begin
      m_hit_slot1 = 1'b1;
      if (m_seq == 2) m_kcnt++;
    end
  endtask

  task automatic model_step();
    bit old_busy, old_run;
    int tgt_eff, nt, fi, si;
    if (RST) begin
      q.delete();
      m_bus = 10'h200;
      {m_busy, m_run, m_err, m_fault, m_armed} = '0;
      m_kcnt = 16'h0;
      m_t = 0;
      m_seq = 0;
      m_pos = 0;
      return;
    end
    old_busy = m_busy;
    old_run = m_run;
    tgt_eff = m_armed ? int'(m_f) : m_tgt;
    m_hit_slot1 = 1'b0;
    nt = (m_t < 255) ? m_t + 1 : 255;
    if (m_busy && bus_if.WD_RSTOUT) begin
      q.delete();
      m_bus = 10'h200;
      m_busy = 0;
      m_run = 0;
      m_fault = 1;
    end else if (!m_busy) begin
      m_bus = 10'h200;
      if (START) begin
        fi = int'(cfg_f);
        si = int'(cfg_s);
        if (fi >= si + 2 && si + (fi - si) / 2 >= 6) begin
          m_f = cfg_f;
          m_s = cfg_s;
          m_r = cfg_r;
          m_tgt = si + (fi - si) / 2;
          m_err = 0;
          m_fault = 0;
          m_busy = 1;
          push_seq(0);
          advance();
        end else begin
          m_err = 1;
        end
      end
    end else if (q.size() != 0) begin
      advance();
    end else if (STOP) begin
      m_busy = 0;
      m_run = 0;
      m_bus = 10'h200;
    end else if (m_seq == 0) begin
      push_seq(1);
      advance();
    end else begin
      m_run = 1;
      if (nt == tgt_eff - 2) begin
        push_seq(2);
        advance();
      end else begin
        m_bus = 10'h200;
      end
    end
    m_t = m_hit_slot1 ? 0 : nt;
    if ((m_hit_slot1 && m_seq == 2) || !old_busy) m_armed = 0;
    else if (old_run && inj) m_armed = 1;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    check_eq("bus", {22'h0, bus_if.ABUS, bus_if.DBUS}, {22'h0, m_bus});
    check_eq("flags", {28'h0, busy, running, err_cfg, fault},
             {28'h0, m_busy, m_run, m_err, m_fault});
    check_eq("kick_cnt", {16'h0, kick_cnt}, {16'h0, m_kcnt});
  endtask

  task automatic wait_beat(input int seq, input int pos, input string tag);
    int i;
    i = 0;
    while (!(m_busy && m_seq == seq && m_pos == pos) && i < 40) begin
      tick();
      i++;
    end
    check_eq(tag, {31'h0, busy}, 32'h1);
    check_eq({tag, "_sync"}, (m_busy && m_seq == seq && m_pos == pos) ? 32'h1 : 32'h0, 32'h1);
  endtask

  logic [9:0] nom_tbl [12];

  initial begin
    int n;
    logic [15:0] k0;
    nom_tbl = '{10'h0AA, 10'h055, 10'h00A, 10'h103, 10'h304, 10'h200,
                10'h0AA, 10'h055, 10'h208, 10'h200, 10'h200, 10'h200};
    RST = 1'b1; START = 1'b0; STOP = 1'b0; inj = 1'b0;
    cfg_f = 8'h0A; cfg_s = 8'h03; cfg_r = 8'h04;
    bus_if.WD_RSTOUT = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    check_eq("rst_bus", {22'h0, bus_if.ABUS, bus_if.DBUS}, 32'h200);
    check_eq("rst_flags", {28'h0, busy, running, err_cfg, fault}, 32'h0);
    check_eq("rst_kcnt", {16'h0, kick_cnt}, 32'h0);

    // Nominal config/init sequence then periodic kicks at TGT=6.
    for (int i = 0; i < 12; i++) begin
      START = (i == 0);
      tick();
      START = 1'b0;
      check_eq("nom_seq", {22'h0, bus_if.ABUS, bus_if.DBUS}, {22'h0, nom_tbl[i]});
    end
    tick();
    check_eq("kick_unlk1", {22'h0, bus_if.ABUS, bus_if.DBUS}, 32'h0AA);
    check_eq("running", {31'h0, running}, 32'h1);
    tick();
    tick();
    check_eq("kick1_bus", {22'h0, bus_if.ABUS, bus_if.DBUS}, 32'h204);
    check_eq("kick1_cnt", {16'h0, kick_cnt}, 32'h1);
    repeat (6) tick();
    check_eq("kick2_cnt", {16'h0, kick_cnt}, 32'h2);
    repeat (6) tick();
    check_eq("kick3_cnt", {16'h0, kick_cnt}, 32'h3);

`ifdef WDSEQ_FAULT_INJ_EN
    // One late kick at t == F (10 cycles after previous SLOT1), then back to 6.
    wait_beat(2, 3, "inj_sync");
    k0 = kick_cnt;
    n = 0;
    inj = 1'b1;
    while (n < 40) begin
      tick();
      inj = 1'b0;
      n++;
      if (kick_cnt != k0) break;
    end
    check_eq("late_gap", n, 9);
    k0 = kick_cnt;
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (kick_cnt != k0) break;
    end
    check_eq("norm_gap", n, 6);
`endif

    // STOP during kick UNLK2: sequence completes, then idle with no more kicks.
    wait_beat(2, 1, "stop_sync");
    STOP = 1'b1;
    repeat (4) tick();
    check_eq("stop_slot4_busy", {31'h0, busy}, 32'h1);
    tick();
    check_eq("stop_idle", {30'h0, busy, running}, 32'h0);
    repeat (15) tick();
    check_eq("stop_bus", {22'h0, bus_if.ABUS, bus_if.DBUS}, 32'h200);
    STOP = 1'b0;

    // Rejected config (TGT=4).
    cfg_f = 8'h05; cfg_s = 8'h03;
    START = 1'b1;
    tick();
    START = 1'b0;
    check_eq("rej_err", {31'h0, err_cfg}, 32'h1);
    check_eq("rej_busy", {31'h0, busy}, 32'h0);
    tick();
    check_eq("rej_bus", {22'h0, bus_if.ABUS, bus_if.DBUS}, 32'h200);

    // Valid start clears ERR_CFG; RSTOUT in CFG SLOT2 aborts.
    cfg_f = 8'h0A; cfg_s = 8'h03;
    START = 1'b1;
    tick();
    START = 1'b0;
    check_eq("restart_err", {31'h0, err_cfg}, 32'h0);
    wait_beat(0, 3, "abort_sync");
    bus_if.WD_RSTOUT = 1'b1;
    tick();
    bus_if.WD_RSTOUT = 1'b0;
    check_eq("abort_bus", {22'h0, bus_if.ABUS, bus_if.DBUS}, 32'h200);
    check_eq("abort_fault", {31'h0, fault}, 32'h1);
    check_eq("abort_idle", {30'h0, busy, running}, 32'h0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      RST   = ($urandom_range(0, 799) == 0);
      START = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 49) == 0) STOP = ~STOP;
      bus_if.WD_RSTOUT = ($urandom_range(0, 149) == 0);
`ifdef WDSEQ_FAULT_INJ_EN
      inj = ($urandom_range(0, 29) == 0);
`endif
      cfg_f = 8'($urandom_range(0, 40));
      cfg_s = 8'($urandom_range(0, 20));
      cfg_r = 8'($urandom_range(0, 255));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
